// File: rtl/tl_ram_responder.sv
// tl_ram_responder: TL-UL responder with one outstanding transaction, backed by a
// byte-writable, word-addressed synchronous RAM. Accept -> check/access -> respond.
module tl_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic [2:0]  tl_a_opcode,
    input  logic [2:0]  tl_a_param,
    input  logic [3:0]  tl_a_size,
    input  logic [31:0] tl_a_address,
    input  logic [3:0]  tl_a_mask,
    input  logic [31:0] tl_a_data,
    input  logic        tl_a_corrupt,
    input  logic        tl_a_valid,
    output logic        tl_a_ready,
    output logic [2:0]  tl_d_opcode,
    output logic [1:0]  tl_d_param,
    output logic [3:0]  tl_d_size,
    output logic        tl_d_denied,
    output logic [31:0] tl_d_data,
    output logic        tl_d_corrupt,
    output logic        tl_d_valid,
    input  logic        tl_d_ready
);
    localparam int unsigned IdxW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] RangeBytes = 33'(DEPTH_WORDS) << 2;

    localparam logic [2:0] OpPutFull  = 3'd0;
    localparam logic [2:0] OpPutPart  = 3'd1;
    localparam logic [2:0] OpGet      = 3'd4;
    localparam logic [2:0] OpAck      = 3'd0;
    localparam logic [2:0] OpAckData  = 3'd1;

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        a_ready_q, a_ready_d;
    logic        d_valid_q, d_valid_d;
    logic [2:0]  d_opcode_q, d_opcode_d;
    logic [3:0]  d_size_q, d_size_d;
    logic        d_denied_q, d_denied_d;
    logic        d_corrupt_q, d_corrupt_d;
    logic        d_rdsel_q, d_rdsel_d;
    logic [2:0]  req_op_q, req_op_d;
    logic [3:0]  req_size_q, req_size_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  req_mask_q, req_mask_d;
    logic [31:0] req_data_q, req_data_d;
    logic        req_corrupt_q, req_corrupt_d;

    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rdata_q;
    logic [31:0]     offset;
    logic [IdxW-1:0] word_idx;
    logic            range_err, size_err, align_err, op_err, err;
    logic            is_get, is_put, ram_we, ram_re;
    logic            unused_sig;

    // Request checks on the captured A beat; offset wraps so addresses below BASE are out of range.
    always_comb begin
        offset    = req_addr_q - BASE_ADDR;
        range_err = {1'b0, offset} >= RangeBytes;
        size_err  = req_size_q > 4'd2;
        align_err = 1'b0;
        case (req_size_q)
            4'd1:    align_err = req_addr_q[0];
            4'd2:    align_err = |req_addr_q[1:0];
            default: align_err = 1'b0;
        endcase
        is_get   = req_op_q == OpGet;
        is_put   = (req_op_q == OpPutFull) || (req_op_q == OpPutPart);
        op_err   = !(is_get || is_put);
        err      = range_err | size_err | align_err | op_err;
        word_idx = offset[IdxW+1:2];
        // A reset landing in the access cycle must discard the pending write.
        ram_we   = (state_q == StAccess) && is_put && !err && !req_corrupt_q && !cpu_rst_i;
        ram_re   = (state_q == StAccess) && is_get && !err;
    end

    // Next-state and next-output logic for the accept / access / respond sequence.
    always_comb begin
        state_d       = state_q;
        a_ready_d     = a_ready_q;
        d_valid_d     = d_valid_q;
        d_opcode_d    = d_opcode_q;
        d_size_d      = d_size_q;
        d_denied_d    = d_denied_q;
        d_corrupt_d   = d_corrupt_q;
        d_rdsel_d     = d_rdsel_q;
        req_op_d      = req_op_q;
        req_size_d    = req_size_q;
        req_addr_d    = req_addr_q;
        req_mask_d    = req_mask_q;
        req_data_d    = req_data_q;
        req_corrupt_d = req_corrupt_q;
        case (state_q)
            StIdle: begin
                if (tl_a_valid) begin
                    req_op_d      = tl_a_opcode;
                    req_size_d    = tl_a_size;
                    req_addr_d    = tl_a_address;
                    req_mask_d    = tl_a_mask;
                    req_data_d    = tl_a_data;
                    req_corrupt_d = tl_a_corrupt;
                    a_ready_d     = 1'b0;
                    state_d       = StAccess;
                end
            end
            StAccess: begin
                d_valid_d   = 1'b1;
                d_opcode_d  = is_get ? OpAckData : OpAck;
                d_size_d    = req_size_q;
                d_denied_d  = err;
                d_corrupt_d = is_get & err;
                d_rdsel_d   = is_get & !err;
                state_d     = StResp;
            end
            StResp: begin
                if (tl_d_ready) begin
                    d_valid_d = 1'b0;
                    d_rdsel_d = 1'b0;
                    a_ready_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            state_q       <= StIdle;
            a_ready_q     <= 1'b1;
            d_valid_q     <= 1'b0;
            d_opcode_q    <= 3'd0;
            d_size_q      <= 4'd0;
            d_denied_q    <= 1'b0;
            d_corrupt_q   <= 1'b0;
            d_rdsel_q     <= 1'b0;
            req_op_q      <= 3'd0;
            req_size_q    <= 4'd0;
            req_addr_q    <= 32'd0;
            req_mask_q    <= 4'd0;
            req_data_q    <= 32'd0;
            req_corrupt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_ready_q     <= a_ready_d;
            d_valid_q     <= d_valid_d;
            d_opcode_q    <= d_opcode_d;
            d_size_q      <= d_size_d;
            d_denied_q    <= d_denied_d;
            d_corrupt_q   <= d_corrupt_d;
            d_rdsel_q     <= d_rdsel_d;
            req_op_q      <= req_op_d;
            req_size_q    <= req_size_d;
            req_addr_q    <= req_addr_d;
            req_mask_q    <= req_mask_d;
            req_data_q    <= req_data_d;
            req_corrupt_q <= req_corrupt_d;
        end
    end

    // RAM: per-lane writes and a registered read, both issued in the access cycle.
    always_ff @(posedge cpu_clk_i) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_mask_q[i]) begin
                    mem[word_idx][8*i +: 8] <= req_data_q[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            rdata_q <= mem[word_idx];
        end
    end

    // Read data is only exposed for a successful Get; every other response carries zero.
    assign tl_d_data    = d_rdsel_q ? rdata_q : 32'd0;
    assign tl_a_ready   = a_ready_q;
    assign tl_d_valid   = d_valid_q;
    assign tl_d_opcode  = d_opcode_q;
    assign tl_d_param   = 2'b00;
    assign tl_d_size    = d_size_q;
    assign tl_d_denied  = d_denied_q;
    assign tl_d_corrupt = d_corrupt_q;

    assign unused_sig = ^{tl_a_param, offset};

endmodule

// File: tb/tb_tl_ram_responder.sv
// Bench for tl_ram_responder: directed steps plus random traffic against a byte-array model.
module tb_tl_ram_responder;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  tl_a_opcode;
    logic [2:0]  tl_a_param;
    logic [3:0]  tl_a_size;
    logic [31:0] tl_a_address;
    logic [3:0]  tl_a_mask;
    logic [31:0] tl_a_data;
    logic        tl_a_corrupt;
    logic        tl_a_valid;
    logic        tl_a_ready;
    logic [2:0]  tl_d_opcode;
    logic [1:0]  tl_d_param;
    logic [3:0]  tl_d_size;
    logic        tl_d_denied;
    logic [31:0] tl_d_data;
    logic        tl_d_corrupt;
    logic        tl_d_valid;
    logic        tl_d_ready;

    always #5 clk = ~clk;

    tl_ram_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .cpu_clk_i   (clk),
        .cpu_rst_i   (rst),
        .tl_a_opcode (tl_a_opcode),
        .tl_a_param  (tl_a_param),
        .tl_a_size   (tl_a_size),
        .tl_a_address(tl_a_address),
        .tl_a_mask   (tl_a_mask),
        .tl_a_data   (tl_a_data),
        .tl_a_corrupt(tl_a_corrupt),
        .tl_a_valid  (tl_a_valid),
        .tl_a_ready  (tl_a_ready),
        .tl_d_opcode (tl_d_opcode),
        .tl_d_param  (tl_d_param),
        .tl_d_size   (tl_d_size),
        .tl_d_denied (tl_d_denied),
        .tl_d_data   (tl_d_data),
        .tl_d_corrupt(tl_d_corrupt),
        .tl_d_valid  (tl_d_valid),
        .tl_d_ready  (tl_d_ready)
    );

    logic [7:0] mem_model [BYTES];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: decide the response from the request rules and apply writes.
    function automatic void model_txn(input logic [2:0] op, input logic [3:0] size,
                                      input logic [31:0] addr, input logic [3:0] mask,
                                      input logic [31:0] data, input logic corrupt,
                                      output logic [2:0] e_op, output logic e_den,
                                      output logic e_cor, output logic [31:0] e_data);
        logic [31:0] off;
        bit          err;
        int unsigned wb;
        off = addr - BASE;
        err = 0;
        if (off >= BYTES) err = 1;
        if (size > 4'd2) err = 1;
        else if ((addr % (32'd1 << size)) != 0) err = 1;
        if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) err = 1;
        wb     = (off / 4) * 4;
        e_op   = 3'd0;
        e_den  = err;
        e_cor  = 1'b0;
        e_data = 32'd0;
        if (op == 3'd4) begin
            e_op  = 3'd1;
            e_cor = err;
            if (!err) e_data = {mem_model[wb+3], mem_model[wb+2], mem_model[wb+1], mem_model[wb]};
        end else if ((op == 3'd0 || op == 3'd1) && !err && !corrupt) begin
            for (int i = 0; i < 4; i++) begin
                if (mask[i]) mem_model[wb+i] = data[8*i +: 8];
            end
        end
    endfunction

    task automatic check_fields(input string tag, input logic [2:0] e_op, input logic [3:0] e_size,
                                input logic e_den, input logic [31:0] e_data, input logic e_cor);
        check({tag, ".d_opcode"}, 32'(tl_d_opcode), 32'(e_op));
        check({tag, ".d_param"}, 32'(tl_d_param), 32'd0);
        check({tag, ".d_size"}, 32'(tl_d_size), 32'(e_size));
        check({tag, ".d_denied"}, 32'(tl_d_denied), 32'(e_den));
        check({tag, ".d_data"}, tl_d_data, e_data);
        check({tag, ".d_corrupt"}, 32'(tl_d_corrupt), 32'(e_cor));
    endtask

    // One full transaction; stall>0 holds D back-pressure while a second A beat waits.
    task automatic txn(input string tag, input logic [2:0] op, input logic [3:0] size,
                       input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic corrupt, input int stall);
        logic [2:0]  e_op;
        logic        e_den, e_cor;
        logic [31:0] e_data;
        int          lat;
        model_txn(op, size, addr, mask, data, corrupt, e_op, e_den, e_cor, e_data);
        check({tag, ".a_ready"}, 32'(tl_a_ready), 32'd1);
        tl_a_opcode  = op;
        tl_a_param   = 3'($urandom);
        tl_a_size    = size;
        tl_a_address = addr;
        tl_a_mask    = mask;
        tl_a_data    = data;
        tl_a_corrupt = corrupt;
        tl_a_valid   = 1'b1;
        tl_d_ready   = (stall == 0);
        @(posedge clk); #1;
        tl_a_valid = 1'b0;
        lat = 1;
        while (!tl_d_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd2);
        check_fields(tag, e_op, size, e_den, e_data, e_cor);
        if (stall > 0) begin
            tl_a_valid   = 1'b1;
            tl_a_opcode  = 3'd4;
            tl_a_address = BASE;
            repeat (stall) begin
                @(posedge clk); #1;
                check({tag, ".stall.d_valid"}, 32'(tl_d_valid), 32'd1);
                check({tag, ".stall.a_ready"}, 32'(tl_a_ready), 32'd0);
                check_fields({tag, ".stall"}, e_op, size, e_den, e_data, e_cor);
            end
            tl_d_ready = 1'b1;
        end
        @(posedge clk); #1;
        tl_a_valid = 1'b0;
        check({tag, ".post.d_valid"}, 32'(tl_d_valid), 32'd0);
        check({tag, ".post.a_ready"}, 32'(tl_a_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [3:0]  size;
        logic [31:0] addr;
        int          r;

        rst = 1'b1;
        tl_a_opcode = 3'd0; tl_a_param = 3'd0; tl_a_size = 4'd0; tl_a_address = 32'd0;
        tl_a_mask = 4'd0; tl_a_data = 32'd0; tl_a_corrupt = 1'b0; tl_a_valid = 1'b0;
        tl_d_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.a_ready", 32'(tl_a_ready), 32'd1);
        check("reset.d_valid", 32'(tl_d_valid), 32'd0);
        check_fields("reset", 3'd0, 4'd0, 1'b0, 32'd0, 1'b0);

        // Give every word a known value.
        for (int w = 0; w < int'(DEPTH); w++) begin
            txn("init", 3'd0, 4'd2, BASE + 32'(w * 4), 4'hF, $urandom, 1'b0, 0);
        end

        txn("put_full", 3'd0, 4'd2, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 0);
        txn("get_full", 3'd4, 4'd2, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 0);
        check("get_full.const", tl_d_data, 32'd0);
        txn("put_part", 3'd1, 4'd1, BASE + 32'h12, 4'b1100, 32'h1234_0000, 1'b0, 0);
        txn("get_part", 3'd4, 4'd2, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 0);
        txn("get_oob", 3'd4, 4'd2, BASE + BYTES, 4'h0, 32'h0, 1'b0, 0);
        txn("get_last", 3'd4, 4'd2, BASE + BYTES - 4, 4'h0, 32'h0, 1'b0, 0);
        txn("get_below", 3'd4, 4'd2, BASE - 4, 4'h0, 32'h0, 1'b0, 0);
        txn("get_misal", 3'd4, 4'd2, BASE + 32'h2, 4'h0, 32'h0, 1'b0, 0);
        txn("bad_op", 3'd3, 4'd2, BASE + 32'h20, 4'hF, 32'h0, 1'b0, 0);
        txn("bad_size", 3'd4, 4'd3, BASE + 32'h20, 4'h0, 32'h0, 1'b0, 0);
        txn("put_corrupt", 3'd0, 4'd2, BASE + 32'h20, 4'hF, 32'hA5A5_5A5A, 1'b1, 0);
        txn("get_after_corrupt", 3'd4, 4'd2, BASE + 32'h20, 4'h0, 32'h0, 1'b0, 0);
        for (int b = 0; b < 4; b++) begin
            txn("get_b0", 3'd4, 4'd0, BASE + 32'h30 + 32'(b), 4'h0, 32'h0, 1'b0, 0);
        end
        txn("get_h1", 3'd4, 4'd1, BASE + 32'h31, 4'h0, 32'h0, 1'b0, 0);
        txn("get_h3", 3'd4, 4'd1, BASE + 32'h33, 4'h0, 32'h0, 1'b0, 0);
        txn("stall5", 3'd4, 4'd2, BASE + 32'h10, 4'h0, 32'h0, 1'b0, 5);

        // Reset while a response is waiting.
        tl_a_opcode = 3'd4; tl_a_size = 4'd2; tl_a_address = BASE + 32'h10;
        tl_a_valid = 1'b1; tl_d_ready = 1'b0;
        @(posedge clk); #1;
        tl_a_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_resp.pre_valid", 32'(tl_d_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tl_d_ready = 1'b1;
        check("rst_resp.d_valid", 32'(tl_d_valid), 32'd0);
        check("rst_resp.a_ready", 32'(tl_a_ready), 32'd1);
        check_fields("rst_resp", 3'd0, 4'd0, 1'b0, 32'd0, 1'b0);

        // Reset during the access cycle of a Put; the word must keep its old value.
        tl_a_opcode = 3'd0; tl_a_size = 4'd2; tl_a_address = BASE + 32'h40;
        tl_a_mask = 4'hF; tl_a_data = 32'h0BAD_F00D; tl_a_corrupt = 1'b0; tl_a_valid = 1'b1;
        @(posedge clk); #1;
        tl_a_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_access.d_valid", 32'(tl_d_valid), 32'd0);
        check("rst_access.a_ready", 32'(tl_a_ready), 32'd1);
        txn("rst_access.get", 3'd4, 4'd2, BASE + 32'h40, 4'h0, 32'h0, 1'b0, 0);

        // Random traffic.
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) op = 3'd4;
            else if (r < 6) op = 3'd0;
            else if (r < 8) op = 3'd1;
            else op = 3'($urandom_range(0, 7));
            size = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : 4'd2;
            if ($urandom_range(0, 7) == 0) begin
                addr = $urandom;
            end else begin
                addr = BASE + 32'($urandom_range(0, BYTES - 1));
                if (size <= 4'd2 && $urandom_range(0, 3) != 0) begin
                    addr = addr & ~((32'd1 << size) - 32'd1);
                end
            end
            txn("rand", op, size, addr, 4'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
